// File: rtl/mem_req_queue.sv
// mem_req_queue
//   Request front-end for the 64x8 memory stage. Client read/write commands
//   are buffered in an in-order command queue, issued at most one per cycle
//   onto registered mem_req_* outputs, and read returns are collected in a
//   response queue. Reads only issue when a response slot is reserved for
//   them, so the memory side is never backpressured.
//
//   Ports:
//     clk, rst                 clock; asynchronous active-high reset
//     cmd_vld/cmd_rdy          client command handshake
//     cmd_op/cmd_addr/cmd_data command (op encoding in mem_req_queue_pkg::op_e)
//     rsp_vld/rsp_rdy/rsp_data read response handshake
//     mem_rst                  memory-bus reset (released 2 edges after rst)
//     mem_req_op/addr/data     registered request to memory
//     mem_rsp_vld/mem_rsp_data memory read return (single-cycle latency)
//     stat_wr_cnt/stat_rd_cnt  saturating issue counters, present only when
//                              MEM_REQ_QUEUE_STATS_EN is defined

package mem_req_queue_pkg;
  typedef enum logic [1:0] {
    OP_INVALID = 2'd0,
    OP_READ    = 2'd1,
    OP_WRITE   = 2'd2
  } op_e;
endpackage

module mem_req_queue
  import mem_req_queue_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_rst,
  output logic [1:0]        mem_req_op,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_rsp_vld,
  input  logic [DATA_W-1:0] mem_rsp_data
`ifdef MEM_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_rd_cnt
`endif
);

  localparam int unsigned CPW = $clog2(CMD_DEPTH);
  localparam int unsigned RPW = $clog2(RSP_DEPTH);
  localparam logic [CPW:0]   CQ_FULL    = (CPW+1)'(CMD_DEPTH);
  localparam logic [RPW+1:0] RQ_CREDITS = (RPW+2)'(RSP_DEPTH);

  typedef enum logic [1:0] {
    ST_RST0,
    ST_RST1,
    ST_RUN
  } rst_st_e;

  rst_st_e st_q, st_d;

  // Command queue
  op_e               cq_op_q   [CMD_DEPTH];
  logic [ADDR_W-1:0] cq_addr_q [CMD_DEPTH];
  logic [DATA_W-1:0] cq_data_q [CMD_DEPTH];
  logic [CPW-1:0]    cq_wr_ptr_q, cq_wr_ptr_d;
  logic [CPW-1:0]    cq_rd_ptr_q, cq_rd_ptr_d;
  logic [CPW:0]      cq_cnt_q, cq_cnt_d;

  // Response queue
  logic [DATA_W-1:0] rq_data_q [RSP_DEPTH];
  logic [RPW-1:0]    rq_wr_ptr_q, rq_wr_ptr_d;
  logic [RPW-1:0]    rq_rd_ptr_q, rq_rd_ptr_d;
  logic [RPW:0]      rq_cnt_q, rq_cnt_d;

  // Reads issued but not yet returned. The issue-to-return round trip spans
  // two edges, so a second read may issue before the first returns; a count
  // keeps the credit exact where a single flag would lose one.
  logic [RPW:0]      infl_q, infl_d;

  op_e               mem_req_op_q, mem_req_op_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_W-1:0] mem_req_data_q, mem_req_data_d;

  op_e  cmd_op_e;
  op_e  head_op;
  logic cmd_push;
  logic head_vld;
  logic credit_ok;
  logic issue_rd;
  logic issue_wr;
  logic cq_pop;
  logic rsp_push;
  logic rsp_pop;

  // Memory-bus reset sequencer: held while rst, released on 2nd edge after.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_RST0: st_d = ST_RST1;
      ST_RST1: st_d = ST_RUN;
      ST_RUN:  st_d = ST_RUN;
      default: st_d = ST_RST0;
    endcase
  end

  assign mem_rst = (st_q != ST_RUN);

  // Ready derives from the registered count only; rst gating keeps it low
  // for the whole reset pulse.
  assign cmd_rdy = !rst && (cq_cnt_q < CQ_FULL);

  assign rsp_vld  = (rq_cnt_q != '0);
  assign rsp_data = rq_data_q[rq_rd_ptr_q];

  assign mem_req_op   = mem_req_op_q;
  assign mem_req_addr = mem_req_addr_q;
  assign mem_req_data = mem_req_data_q;

  always_comb begin
    cmd_op_e  = op_e'(cmd_op);
    cmd_push  = cmd_vld && cmd_rdy && (cmd_op_e == OP_READ || cmd_op_e == OP_WRITE);
    head_vld  = (cq_cnt_q != '0);
    head_op   = cq_op_q[cq_rd_ptr_q];
    credit_ok = ({1'b0, rq_cnt_q} + {1'b0, infl_q}) < RQ_CREDITS;
    issue_wr  = (st_q == ST_RUN) && head_vld && (head_op == OP_WRITE);
    issue_rd  = (st_q == ST_RUN) && head_vld && (head_op == OP_READ) && credit_ok;
    cq_pop    = issue_wr || issue_rd;
    rsp_push  = mem_rsp_vld && (infl_q != '0);
    rsp_pop   = rsp_vld && rsp_rdy;

    cq_wr_ptr_d = cmd_push ? cq_wr_ptr_q + CPW'(1) : cq_wr_ptr_q;
    cq_rd_ptr_d = cq_pop   ? cq_rd_ptr_q + CPW'(1) : cq_rd_ptr_q;
    cq_cnt_d    = cq_cnt_q;
    case ({cmd_push, cq_pop})
      2'b10:   cq_cnt_d = cq_cnt_q + (CPW+1)'(1);
      2'b01:   cq_cnt_d = cq_cnt_q - (CPW+1)'(1);
      default: cq_cnt_d = cq_cnt_q;
    endcase

    rq_wr_ptr_d = rsp_push ? rq_wr_ptr_q + RPW'(1) : rq_wr_ptr_q;
    rq_rd_ptr_d = rsp_pop  ? rq_rd_ptr_q + RPW'(1) : rq_rd_ptr_q;
    rq_cnt_d    = rq_cnt_q;
    case ({rsp_push, rsp_pop})
      2'b10:   rq_cnt_d = rq_cnt_q + (RPW+1)'(1);
      2'b01:   rq_cnt_d = rq_cnt_q - (RPW+1)'(1);
      default: rq_cnt_d = rq_cnt_q;
    endcase

    infl_d = infl_q;
    case ({issue_rd, rsp_push})
      2'b10:   infl_d = infl_q + (RPW+1)'(1);
      2'b01:   infl_d = infl_q - (RPW+1)'(1);
      default: infl_d = infl_q;
    endcase

    mem_req_op_d   = cq_pop ? head_op : OP_INVALID;
    mem_req_addr_d = cq_pop ? cq_addr_q[cq_rd_ptr_q] : mem_req_addr_q;
    mem_req_data_d = cq_pop ? cq_data_q[cq_rd_ptr_q] : mem_req_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q           <= ST_RST0;
      cq_wr_ptr_q    <= '0;
      cq_rd_ptr_q    <= '0;
      cq_cnt_q       <= '0;
      rq_wr_ptr_q    <= '0;
      rq_rd_ptr_q    <= '0;
      rq_cnt_q       <= '0;
      infl_q         <= '0;
      mem_req_op_q   <= OP_INVALID;
      mem_req_addr_q <= '0;
      mem_req_data_q <= '0;
    end else begin
      st_q           <= st_d;
      cq_wr_ptr_q    <= cq_wr_ptr_d;
      cq_rd_ptr_q    <= cq_rd_ptr_d;
      cq_cnt_q       <= cq_cnt_d;
      rq_wr_ptr_q    <= rq_wr_ptr_d;
      rq_rd_ptr_q    <= rq_rd_ptr_d;
      rq_cnt_q       <= rq_cnt_d;
      infl_q         <= infl_d;
      mem_req_op_q   <= mem_req_op_d;
      mem_req_addr_q <= mem_req_addr_d;
      mem_req_data_q <= mem_req_data_d;
    end
  end

  // Queue storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_op_q[cq_wr_ptr_q]   <= cmd_op_e;
      cq_addr_q[cq_wr_ptr_q] <= cmd_addr;
      cq_data_q[cq_wr_ptr_q] <= cmd_data;
    end
    if (rsp_push) begin
      rq_data_q[rq_wr_ptr_q] <= mem_rsp_data;
    end
  end

`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_rd_q, stat_rd_d;

  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_rd_d = stat_rd_q;
    if (issue_wr && stat_wr_q != '1) stat_wr_d = stat_wr_q + 16'd1;
    if (issue_rd && stat_rd_q != '1) stat_rd_d = stat_rd_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Self-checking bench for mem_req_queue with a 64x8 single-cycle memory model.
module tb_mem_req_queue;

  localparam logic [1:0] OP_INV = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] addr;
    logic [7:0] data;
  } iss_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_vld = 1'b0;
  logic       cmd_rdy;
  logic [1:0] cmd_op = 2'd0;
  logic [5:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_vld;
  logic       rsp_rdy = 1'b0;
  logic [7:0] rsp_data;
  logic       mem_rst;
  logic [1:0] mem_req_op;
  logic [5:0] mem_req_addr;
  logic [7:0] mem_req_data;
  logic       mem_rsp_vld = 1'b0;
  logic [7:0] mem_rsp_data = '0;
`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_rd_cnt;
`endif

  mem_req_queue #(
    .ADDR_W(6),
    .DATA_W(8),
    .CMD_DEPTH(4),
    .RSP_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data),
    .mem_rst(mem_rst),
    .mem_req_op(mem_req_op),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_rsp_vld(mem_rsp_vld),
    .mem_rsp_data(mem_rsp_data)
`ifdef MEM_REQ_QUEUE_STATS_EN
    ,
    .stat_wr_cnt(stat_wr_cnt),
    .stat_rd_cnt(stat_rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: not reset by mem_rst, so a return launched before a reset
  // still reaches the DUT afterwards.
  logic [7:0] mem    [64];
  logic [7:0] shadow [64];
  always @(posedge clk) begin
    if (mem_req_op == OP_WR) mem[mem_req_addr] <= mem_req_data;
    mem_rsp_vld  <= (mem_req_op == OP_RD);
    mem_rsp_data <= mem[mem_req_addr];
  end

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  iss_t        iss_q [$];
  logic [7:0]  rsp_q [$];
  int unsigned n_rd_iss = 0;
  int unsigned n_wr_iss = 0;
  int unsigned rd_iss_cyc = 0;
  int unsigned wr_iss_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: issue order and response data against the scoreboard.
  iss_t       mon_e;
  logic [7:0] mon_d;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_op != OP_INV) begin
        if (mem_req_op == OP_RD) begin
          n_rd_iss++;
          rd_iss_cyc = cyc;
        end else begin
          n_wr_iss++;
          wr_iss_cyc = cyc;
        end
        check_eq("iss_mem_rst", 32'(mem_rst), 32'd0);
        check_eq("iss_expected", 32'(iss_q.size() != 0), 32'd1);
        if (iss_q.size() != 0) begin
          mon_e = iss_q.pop_front();
          check_eq("iss_op", 32'(mem_req_op), 32'(mon_e.op));
          check_eq("iss_addr", 32'(mem_req_addr), 32'(mon_e.addr));
          if (mon_e.op == OP_WR) check_eq("iss_data", 32'(mem_req_data), 32'(mon_e.data));
        end
      end
      if (rsp_vld && rsp_rdy) begin
        check_eq("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          mon_d = rsp_q.pop_front();
          check_eq("rsp_data", 32'(rsp_data), 32'(mon_d));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [1:0] op, input logic [5:0] addr,
                      input logic [7:0] data, output int unsigned hs);
    int unsigned waited;
    waited   = 0;
    hs       = 0;
    cmd_vld  = 1'b1;
    cmd_op   = op;
    cmd_addr = addr;
    cmd_data = data;
    @(negedge clk);
    while (!cmd_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_rdy) check_eq("cmd_rdy_wait", 32'(cmd_rdy), 32'd1);
    else begin
      hs = cyc + 1;
      if (op == OP_WR) begin
        shadow[addr] = data;
        iss_q.push_back('{op: op, addr: addr, data: data});
      end else if (op == OP_RD) begin
        iss_q.push_back('{op: op, addr: addr, data: data});
        rsp_q.push_back(shadow[addr]);
      end
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    cmd_op  = OP_INV;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && iss_q.size() == 0) break;
    end
    check_eq({tag, "_iss_left"}, iss_q.size(), 32'd0);
    check_eq({tag, "_rsp_left"}, rsp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned hw, hr, rd0, rsp_cyc;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 8'h00;
      shadow[i] = 8'h00;
    end

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check_eq("rst_mem_op", 32'(mem_req_op), 32'(OP_INV));
    check_eq("rst_mem_addr", 32'(mem_req_addr), 32'd0);
    check_eq("rst_mem_data", 32'(mem_req_data), 32'd0);
    check_eq("rst_mem_rst", 32'(mem_rst), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rel_cmd_rdy", 32'(cmd_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rel_mem_rst", 32'(mem_rst), (i < 2) ? 32'd1 : 32'd0);
      check_eq("rel_mem_op", 32'(mem_req_op), 32'(OP_INV));
    end
    @(posedge clk);
    #1;

    // Write then read back-to-back
    rsp_rdy = 1'b1;
    send(OP_WR, 6'h05, 8'hA5, hw);
    send(OP_RD, 6'h05, 8'h00, hr);
    rsp_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_vld) begin
        rsp_cyc = cyc;
        break;
      end
    end
    check_eq("wr_issue_lat", wr_iss_cyc, hw + 1);
    check_eq("rd_issue_lat", rd_iss_cyc, hr + 1);
    check_eq("rd_follows_wr", rd_iss_cyc, wr_iss_cyc + 1);
    check_eq("rsp_lat", rsp_cyc, hr + 3);
    check_eq("rsp_a5", 32'(rsp_data), 32'hA5);
    drain("wr_rd");

    // Fill with reads while responses are held off
    for (int i = 0; i < 4; i++) send(OP_WR, 6'(8'h10 + i), 8'(8'h40 + 8'(i * 3)), hw);
    drain("fill_wr");
    rsp_rdy = 1'b0;
    rd0 = n_rd_iss;
    send(OP_RD, 6'h10, 8'h00, hr);
    send(OP_RD, 6'h11, 8'h00, hr);
    send(OP_RD, 6'h12, 8'h00, hr);
    send(OP_RD, 6'h13, 8'h00, hr);
    send(OP_RD, 6'h05, 8'h00, hr);
    send(OP_RD, 6'h11, 8'h00, hr);
    check_eq("fill_cmd_rdy", 32'(cmd_rdy), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("fill_rd_issued", n_rd_iss - rd0, 32'd2);
    check_eq("fill_cmd_rdy_hold", 32'(cmd_rdy), 32'd0);
    check_eq("fill_rsp_vld", 32'(rsp_vld), 32'd1);
    @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    drain("fill_rd");
    check_eq("fill_rd_total", n_rd_iss - rd0, 32'd6);

    // INVALID commands are discarded
    rd0 = n_rd_iss + n_wr_iss;
    cmd_vld = 1'b1;
    cmd_op  = OP_INV;
    cmd_addr = 6'h2A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("inv_cmd_rdy", 32'(cmd_rdy), 32'd1);
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("inv_no_issue", n_rd_iss + n_wr_iss, rd0);
    @(posedge clk);
    #1;

    // Reset while a read is in flight
    send(OP_WR, 6'h22, 8'h5A, hw);
    send(OP_RD, 6'h22, 8'h00, hr);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_op == OP_RD) break;
    end
    check_eq("mid_rd_on_bus", 32'(mem_req_op), 32'(OP_RD));
    @(posedge clk);
    #1;
    rst = 1'b1;
    iss_q.delete();
    rsp_q.delete();
    #1;
    check_eq("mid_rst_mem_op", 32'(mem_req_op), 32'(OP_INV));
    check_eq("mid_rst_mem_rst", 32'(mem_rst), 32'd1);
    check_eq("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("mid_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("mid_no_rsp", 32'(rsp_vld), 32'd0);
      check_eq("mid_mem_rst", 32'(mem_rst), (i < 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    send(OP_RD, 6'h3F, 8'h00, hr);
    drain("post_rst");

`ifdef MEM_REQ_QUEUE_STATS_EN
    rst = 1'b1;
    iss_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("stat_wr_rst", 32'(stat_wr_cnt), 32'd0);
    send(OP_WR, 6'h01, 8'h11, hw);
    send(OP_WR, 6'h02, 8'h22, hw);
    send(OP_RD, 6'h01, 8'h00, hr);
    send(OP_WR, 6'h03, 8'h33, hw);
    send(OP_RD, 6'h03, 8'h00, hr);
    drain("stats");
    check_eq("stat_wr_cnt", 32'(stat_wr_cnt), 32'd3);
    check_eq("stat_rd_cnt", 32'(stat_rd_cnt), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
